pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one control bundle and NUM_WORDS data words per entry, and adds a valid/ready handshake with a 2-entry skid buffer, so stalls propagate without combinational ready paths. It also supports synchronous flush (bubble insertion) and a saturating starvation counter. Instantiated once per stage boundary in the pipelined datapath.

---
 rtl/pipe_stage_skid.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and 2-entry skid buffer.
// Supports synchronous flush and a saturating starvation counter.
module pipe_stage_skid #(
    parameter int                CTRL_W     = 10,
    parameter int                DATA_W     = 32,
    parameter int                NUM_WORDS  = 6,
    parameter logic [CTRL_W-1:0] CTRL_RESET = '0
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [CTRL_W-1:0]           InCtrl,
    input  logic [NUM_WORDS*DATA_W-1:0] InData,
    input  logic                        Flush,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [CTRL_W-1:0]           OutCtrl,
    output logic [NUM_WORDS*DATA_W-1:0] OutData,
    output logic [15:0]                 BubbleCnt
);

    localparam int W = NUM_WORDS * DATA_W;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    typedef enum logic [1:0] {
        M_HOLD,
        M_IN,
        M_SKID,
        M_CLR
    } msel_t;

    state_t            state;
    state_t            state_nxt;
    msel_t             msel;
    logic              skid_ld;
    logic              skid_clr;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [W-1:0]      skid_data;
    logic              acc;
    logic              drn;

    // Handshake flags come from registered state only.
    assign InReady  = (state != TWO);
    assign OutValid = (state != EMPTY);
    assign acc      = InValid & InReady;
    assign drn      = OutValid & OutReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        msel      = M_HOLD;
        skid_ld   = 1'b0;
        skid_clr  = 1'b0;
        if (Flush) begin
            state_nxt = EMPTY;
            msel      = M_CLR;
            skid_clr  = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = ONE;
                        msel      = M_IN;
                    end else begin
                        msel = M_CLR;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        msel = M_IN;
                    end else if (acc) begin
                        state_nxt = TWO;
                        skid_ld   = 1'b1;
                    end else if (drn) begin
                        state_nxt = EMPTY;
                        msel      = M_CLR;
                    end
                end
                TWO: begin
                    if (drn) begin
                        state_nxt = ONE;
                        msel      = M_SKID;
                        skid_clr  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    msel      = M_CLR;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            OutCtrl <= CTRL_RESET;
            OutData <= '0;
        end else begin
            unique case (msel)
                M_IN: begin
                    OutCtrl <= InCtrl;
                    OutData <= InData;
                end
                M_SKID: begin
                    OutCtrl <= skid_ctrl;
                    OutData <= skid_data;
                end
                M_CLR: begin
                    OutCtrl <= CTRL_RESET;
                    OutData <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            skid_ctrl <= CTRL_RESET;
            skid_data <= '0;
        end else if (skid_clr) begin
            skid_ctrl <= CTRL_RESET;
            skid_data <= '0;
        end else if (skid_ld) begin
            skid_ctrl <= InCtrl;
            skid_data <= InData;
        end
    end

    // Flush deliberately leaves the starvation count alone.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BubbleCnt <= 16'd0;
        end else if (OutReady && !OutValid && BubbleCnt != 16'hFFFF) begin
            BubbleCnt <= BubbleCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue-based FIFO model.
// Randomised traffic plus directed fill, flush, saturation and reset cases.
module tb_pipe_stage_skid;

    localparam int CW = 10;
    localparam int DW = 32;
    localparam int NW = 6;
    localparam int W  = NW * DW;
    localparam logic [CW-1:0] CRST = '0;
    localparam int VW = 1 + 1 + CW + W + 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          InValid;
    logic          InReady;
    logic [CW-1:0] InCtrl;
    logic [W-1:0]  InData;
    logic          Flush;
    logic          OutValid;
    logic          OutReady;
    logic [CW-1:0] OutCtrl;
    logic [W-1:0]  OutData;
    logic [15:0]   BubbleCnt;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [W-1:0]  d;
    } ent_t;

    ent_t        q[$];
    logic [15:0] bcnt;
    int          n_cmp = 0;
    int          n_fail = 0;

    pipe_stage_skid #(
        .CTRL_W(CW), .DATA_W(DW), .NUM_WORDS(NW), .CTRL_RESET(CRST)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .InValid(InValid), .InReady(InReady),
        .InCtrl(InCtrl), .InData(InData),
        .Flush(Flush),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutCtrl(OutCtrl), .OutData(OutData),
        .BubbleCnt(BubbleCnt)
    );

    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int k = 0; k < NW; k++) d[k*DW +: DW] = $urandom;
        return d;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic          v = (q.size() != 0);
        logic          r = (q.size() < 2);
        logic [CW-1:0] c = v ? q[0].c : CRST;
        logic [W-1:0]  d = v ? q[0].d : '0;
        return {v, r, c, d, bcnt};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {OutValid, InReady, OutCtrl, OutData, BubbleCnt};
    endfunction

    // Drives one cycle and advances the FIFO model across the edge.
    task automatic cycle(input logic iv, input logic [CW-1:0] c,
                         input logic [W-1:0] d, input logic ordy,
                         input logic fl);
        logic acc, drn, bub;
        InValid  = iv;
        InCtrl   = c;
        InData   = d;
        OutReady = ordy;
        Flush    = fl;
        acc = iv && (q.size() < 2);
        drn = ordy && (q.size() != 0);
        bub = ordy && (q.size() == 0);
        @(posedge Clk);
        if (bub && bcnt != 16'hFFFF) bcnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{c: c, d: d});
        end
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        InValid = 1'b0; InCtrl = '0; InData = '0;
        Flush = 1'b0; OutReady = 1'b0;
        q.delete();
        bcnt = 16'd0;
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] d;
        for (int k = 0; k < NW; k++) d[k*DW +: DW] = 32'h1000 + k;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 10'h155, d, 1'b1, 1'b0);
            n_cmp++;
            if (dut_vec() !== exp_vec() || InReady !== 1'b1) begin
                n_fail++;
                $display("FAIL stream[%0d] got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (BubbleCnt !== 16'd1) begin
            n_fail++;
            $display("FAIL stream_bcnt got %0d want 1", BubbleCnt);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream_drain[%0d] got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, CW'(10'h0A0 + i), rand_data(), 1'b0, 1'b0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bp_fill[%0d] got %h want %h",
                         i, dut_vec(), exp_vec());
            end
            if (i >= 1) begin
                n_cmp++;
                if (InReady !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ready[%0d] got %b want 0", i, InReady);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bp_drain[%0d] got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flush_two();
        cycle(1'b1, 10'h0AA, rand_data(), 1'b0, 1'b0);
        cycle(1'b1, 10'h0BB, rand_data(), 1'b0, 1'b0);
        cycle(1'b1, 10'h0DD, rand_data(), 1'b0, 1'b1);
        n_cmp++;
        if (OutValid !== 1'b0 || OutCtrl !== CRST ||
            OutData !== '0 || InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_two got v=%b r=%b c=%h d=%h want 0 1 0 0",
                     OutValid, InReady, OutCtrl, OutData);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL flush_after[%0d] got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, CW'($urandom), rand_data(), 1'b1, 1'b0);
            n_cmp++;
            if (dut_vec() !== exp_vec() || InReady !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), CW'($urandom), rand_data(),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 29) == 0));
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                if (bad++ < 5)
                    $display("FAIL random[%0d] got %h want %h",
                             i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 10'h011, rand_data(), 1'b0, 1'b0);
        cycle(1'b1, 10'h022, rand_data(), 1'b0, 1'b0);
        #2 Reset = 1'b1;
        q.delete();
        bcnt = 16'd0;
        #1;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset got %h want %h", dut_vec(), exp_vec());
        end
        @(posedge Clk);
        #1 Reset = 1'b0;
        cycle(1'b1, 10'h033, rand_data(), 1'b1, 1'b0);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_bubble_sat();
        for (int i = 0; i < 65600; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (BubbleCnt !== bcnt || BubbleCnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL bcnt_sat got %h want ffff", BubbleCnt);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (BubbleCnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL bcnt_flush got %h want ffff", BubbleCnt);
        end
        do_reset();
        n_cmp++;
        if (BubbleCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL bcnt_reset got %h want 0", BubbleCnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_two();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_bubble_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
